// File: rtl/sdram_bank_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bank_sequencer_if
// Description : Request/response bus between a client and the SDRAM bank
//               sequencer.
//   req_valid  client -> seq  request present
//   req_ready  seq -> client  sequencer can accept a request
//   req_we     client -> seq  1=write, 0=read
//   req_addr   client -> seq  {bank,row,col}
//   req_wdata  client -> seq  write data
//   rsp_valid  seq -> client  one-cycle completion pulse
//   rsp_we     seq -> client  type of the completed access
//   rsp_rdata  seq -> client  read data (valid with rsp_valid, rsp_we=0)
//   rsp_err    seq -> client  one-cycle tRCD timeout abort pulse
//   Modports: master = client side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_bank_sequencer_if #(
  parameter int BA_W   = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int DATA_W = 16
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_we;
  logic [BA_W+ROW_W+COL_W-1:0]   req_addr;
  logic [DATA_W-1:0]             req_wdata;
  logic                          rsp_valid;
  logic                          rsp_we;
  logic [DATA_W-1:0]             rsp_rdata;
  logic                          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/sdram_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bank_sequencer
// Description : Single-access SDRAM command sequencer. Per request it issues
//               ACTIVE, waits for an external tRCD timer, issues READ/WRITE,
//               waits CAS latency or write recovery, then PRECHARGE and tRP.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   bus        request/response bus (slave modport)
//   rcd_start  tRCD timer start/count enable (held through WAIT_RCD)
//   rcd_done   tRCD timer done interrupt (only honoured in WAIT_RCD)
//   sd_cs_n/sd_ras_n/sd_cas_n/sd_we_n  SDRAM command pins
//   sd_ba, sd_a                        bank and address bus
//   sd_dq_out, sd_dq_oe, sd_dq_in      data bus
//   All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_bank_sequencer #(
  parameter int BA_W        = 2,
  parameter int ROW_W       = 13,
  parameter int COL_W       = 10,
  parameter int DATA_W      = 16,
  parameter int CAS_LAT     = 2,
  parameter int TWR_CYCLES  = 2,
  parameter int TRP_CYCLES  = 2,
  parameter int RCD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  sdram_bank_sequencer_if.slave bus,
  output logic                  rcd_start,
  input  logic                  rcd_done,
  output logic                  sd_cs_n,
  output logic                  sd_ras_n,
  output logic                  sd_cas_n,
  output logic                  sd_we_n,
  output logic [BA_W-1:0]       sd_ba,
  output logic [ROW_W-1:0]      sd_a,
  output logic [DATA_W-1:0]     sd_dq_out,
  output logic                  sd_dq_oe,
  input  logic [DATA_W-1:0]     sd_dq_in
);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] c_cmd_desel = 4'b1111;
  localparam logic [3:0] c_cmd_nop   = 4'b0111;
  localparam logic [3:0] c_cmd_act   = 4'b0011;
  localparam logic [3:0] c_cmd_read  = 4'b0101;
  localparam logic [3:0] c_cmd_write = 4'b0100;
  localparam logic [3:0] c_cmd_pre   = 4'b0010;

  localparam logic [7:0] c_rcd_timeout = 8'(RCD_TIMEOUT);
  localparam logic [7:0] c_cas_lat     = 8'(CAS_LAT);
  localparam logic [7:0] c_twr         = 8'(TWR_CYCLES);
  localparam logic [7:0] c_trp         = 8'(TRP_CYCLES);

  // Clears A10 so READ/WRITE never request auto-precharge. When the address
  // bus is 10 bits or narrower the shift falls off the top and the mask is
  // all ones.
  localparam logic [ROW_W-1:0] c_a10_mask = ~(ROW_W'(1) << 10);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACTIVATE  = 3'd1,
    S_WAIT_RCD  = 3'd2,
    S_RW        = 3'd3,
    S_CAS_WAIT  = 3'd4,
    S_WR_REC    = 3'd5,
    S_PRECHARGE = 3'd6,
    S_WAIT_RP   = 3'd7
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cmd;
  logic [7:0]          r_cnt;
  logic                r_we;
  logic [BA_W-1:0]     r_bank;
  logic [COL_W-1:0]    r_col;
  logic [DATA_W-1:0]   r_wdata;

  logic [BA_W-1:0]     w_req_bank;
  logic [ROW_W-1:0]    w_req_row;
  logic [COL_W-1:0]    w_req_col;
  logic [ROW_W-1:0]    w_col_addr;

  assign w_req_bank = bus.req_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
  assign w_req_row  = bus.req_addr[ROW_W+COL_W-1 -: ROW_W];
  assign w_req_col  = bus.req_addr[COL_W-1:0];
  assign w_col_addr = ROW_W'(r_col) & c_a10_mask;

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = r_cmd;

  // The row is driven onto sd_a straight from the request at the accept
  // edge, so only bank, column, direction and data need to be held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cmd         <= c_cmd_desel;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_bank        <= '0;
      r_col         <= '0;
      r_wdata       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      rcd_start     <= 1'b0;
      sd_ba         <= '0;
      sd_a          <= '0;
      sd_dq_out     <= '0;
      sd_dq_oe      <= 1'b0;
    end else begin
      // Single-cycle strobes default low every cycle.
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      sd_dq_oe      <= 1'b0;
      sd_dq_out     <= '0;

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            r_we          <= bus.req_we;
            r_bank        <= w_req_bank;
            r_col         <= w_req_col;
            r_wdata       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            r_state       <= S_ACTIVATE;
            r_cmd         <= c_cmd_act;
            sd_ba         <= w_req_bank;
            sd_a          <= w_req_row;
            rcd_start     <= 1'b1;
          end
        end

        // rcd_done is deliberately not looked at here.
        S_ACTIVATE: begin
          r_state <= S_WAIT_RCD;
          r_cmd   <= c_cmd_nop;
          r_cnt   <= 8'd1;
        end

        // r_cnt counts WAIT_RCD cycles spent so far, starting at 1.
        S_WAIT_RCD: begin
          if (rcd_done) begin
            r_state   <= S_RW;
            rcd_start <= 1'b0;
            sd_ba     <= r_bank;
            sd_a      <= w_col_addr;
            if (r_we) begin
              r_cmd     <= c_cmd_write;
              sd_dq_oe  <= 1'b1;
              sd_dq_out <= r_wdata;
            end else begin
              r_cmd <= c_cmd_read;
            end
          end else if (r_cnt == c_rcd_timeout) begin
            r_state     <= S_PRECHARGE;
            r_cmd       <= c_cmd_pre;
            rcd_start   <= 1'b0;
            bus.rsp_err <= 1'b1;
            sd_ba       <= r_bank;
            sd_a        <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RW: begin
          r_cmd <= c_cmd_nop;
          if (r_we) begin
            r_state <= S_WR_REC;
            r_cnt   <= c_twr;
          end else begin
            r_state <= S_CAS_WAIT;
            r_cnt   <= c_cas_lat;
          end
        end

        // The edge ending the last CAS_WAIT cycle is the one at which read
        // data is on the bus.
        S_CAS_WAIT: begin
          if (r_cnt == 8'd1) begin
            bus.rsp_rdata <= sd_dq_in;
            bus.rsp_valid <= 1'b1;
            bus.rsp_we    <= 1'b0;
            r_state       <= S_PRECHARGE;
            r_cmd         <= c_cmd_pre;
            sd_ba         <= r_bank;
            sd_a          <= '0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_WR_REC: begin
          if (r_cnt == 8'd1) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_we    <= 1'b1;
            r_state       <= S_PRECHARGE;
            r_cmd         <= c_cmd_pre;
            sd_ba         <= r_bank;
            sd_a          <= '0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_PRECHARGE: begin
          r_state <= S_WAIT_RP;
          r_cmd   <= c_cmd_nop;
          r_cnt   <= c_trp;
        end

        S_WAIT_RP: begin
          if (r_cnt == 8'd1) begin
            r_state       <= S_IDLE;
            r_cmd         <= c_cmd_desel;
            bus.req_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_cmd         <= c_cmd_desel;
          rcd_start     <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_bank_sequencer
// Description : Directed self-checking bench for sdram_bank_sequencer with
//               default parameters (CAS_LAT=2, TWR=2, TRP=2, RCD_TIMEOUT=15).
//               Outputs are checked 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_bank_sequencer;

  localparam int BA_W   = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int DATA_W = 16;

  localparam logic [3:0] DESEL = 4'b1111;
  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] RD    = 4'b0101;
  localparam logic [3:0] WR    = 4'b0100;
  localparam logic [3:0] PRE   = 4'b0010;

  logic              clk = 1'b0;
  logic              reset;
  logic              rcd_start;
  logic              rcd_done;
  logic              sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [BA_W-1:0]   sd_ba;
  logic [ROW_W-1:0]  sd_a;
  logic [DATA_W-1:0] sd_dq_out;
  logic              sd_dq_oe;
  logic [DATA_W-1:0] sd_dq_in;
  logic [3:0]        cmd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

  sdram_bank_sequencer_if #(.BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) bus ();

  sdram_bank_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .rcd_start (rcd_start),
    .rcd_done  (rcd_done),
    .sd_cs_n   (sd_cs_n),
    .sd_ras_n  (sd_ras_n),
    .sd_cas_n  (sd_cas_n),
    .sd_we_n   (sd_we_n),
    .sd_ba     (sd_ba),
    .sd_a      (sd_a),
    .sd_dq_out (sd_dq_out),
    .sd_dq_oe  (sd_dq_oe),
    .sd_dq_in  (sd_dq_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rcd_done = 1'b0;
    sd_dq_in = '0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    tick(); tick();
    n_checks++; if (cmd !== DESEL) begin n_fail++; $display("FAIL rst_cmd: got %b exp %b", cmd, DESEL); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", bus.req_ready); end
    n_checks++; if ({bus.rsp_valid, bus.rsp_err, rcd_start, sd_dq_oe, bus.rsp_we} !== 5'b0) begin
      n_fail++; $display("FAIL rst_strobes: got %b exp 00000", {bus.rsp_valid, bus.rsp_err, rcd_start, sd_dq_oe, bus.rsp_we}); end
    n_checks++; if ({sd_ba, sd_a, sd_dq_out, bus.rsp_rdata} !== '0) begin
      n_fail++; $display("FAIL rst_buses: got ba=%h a=%h dq=%h rd=%h exp all 0", sd_ba, sd_a, sd_dq_out, bus.rsp_rdata); end
    reset = 1'b1;
    tick();
    n_checks++; if (cmd !== DESEL || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_after_rst: got cmd=%b ready=%b exp 1111/1", cmd, bus.req_ready); end
  endtask

  task automatic test_read();
    bus.req_we = 1'b0;
    bus.req_addr = {2'd2, 13'h0123, 10'h045};
    bus.req_valid = 1'b1;
    tick(); // ACTIVATE
    bus.req_valid = 1'b0;
    n_checks++; if (cmd !== ACT || sd_ba !== 2'd2 || sd_a !== 13'h0123) begin
      n_fail++; $display("FAIL rd_active: got cmd=%b ba=%h a=%h exp 0011/2/0123", cmd, sd_ba, sd_a); end
    n_checks++; if (rcd_start !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rd_act_ctl: got start=%b ready=%b exp 1/0", rcd_start, bus.req_ready); end
    tick(); tick(); tick(); // third WAIT_RCD cycle
    n_checks++; if (cmd !== NOP || rcd_start !== 1'b1) begin
      n_fail++; $display("FAIL rd_wait_rcd: got cmd=%b start=%b exp 0111/1", cmd, rcd_start); end
    rcd_done = 1'b1;
    tick(); // READ
    rcd_done = 1'b0;
    n_checks++; if (cmd !== RD || sd_a !== 13'h0045 || sd_ba !== 2'd2 || rcd_start !== 1'b0) begin
      n_fail++; $display("FAIL rd_read: got cmd=%b a=%h ba=%h start=%b exp 0101/0045/2/0", cmd, sd_a, sd_ba, rcd_start); end
    tick(); // CAS 1
    n_checks++; if (cmd !== NOP) begin n_fail++; $display("FAIL rd_cas1: got %b exp %b", cmd, NOP); end
    tick(); // CAS 2 (capture)
    sd_dq_in = 16'hBEEF;
    n_checks++; if (cmd !== NOP || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_cas2: got cmd=%b vld=%b exp 0111/0", cmd, bus.rsp_valid); end
    tick(); // PRECHARGE
    sd_dq_in = 16'h0000;
    n_checks++; if (cmd !== PRE || sd_ba !== 2'd2 || sd_a[10] !== 1'b0) begin
      n_fail++; $display("FAIL rd_pre: got cmd=%b ba=%h a10=%b exp 0010/2/0", cmd, sd_ba, sd_a[10]); end
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_we !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd_rsp: got v=%b we=%b err=%b d=%h exp 1/0/0/beef", bus.rsp_valid, bus.rsp_we, bus.rsp_err, bus.rsp_rdata); end
    tick();
    n_checks++; if (cmd !== NOP || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_rp1: got cmd=%b vld=%b exp 0111/0", cmd, bus.rsp_valid); end
    tick();
    n_checks++; if (cmd !== NOP) begin n_fail++; $display("FAIL rd_rp2: got %b exp %b", cmd, NOP); end
    tick();
    n_checks++; if (cmd !== DESEL || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd_idle: got cmd=%b ready=%b d=%h exp 1111/1/beef", cmd, bus.req_ready, bus.rsp_rdata); end
  endtask

  task automatic test_write();
    bus.req_we = 1'b1;
    bus.req_addr = {2'd1, 13'h1ABC, 10'h3FF};
    bus.req_wdata = 16'hA5A5;
    bus.req_valid = 1'b1;
    tick(); // ACTIVATE
    bus.req_valid = 1'b0;
    n_checks++; if (cmd !== ACT || sd_ba !== 2'd1 || sd_a !== 13'h1ABC) begin
      n_fail++; $display("FAIL wr_active: got cmd=%b ba=%h a=%h exp 0011/1/1abc", cmd, sd_ba, sd_a); end
    tick(); // WAIT_RCD 1
    n_checks++; if (cmd !== NOP || sd_dq_oe !== 1'b0) begin
      n_fail++; $display("FAIL wr_pre_oe: got cmd=%b oe=%b exp 0111/0", cmd, sd_dq_oe); end
    rcd_done = 1'b1;
    tick(); // WRITE
    rcd_done = 1'b0;
    n_checks++; if (cmd !== WR || sd_dq_oe !== 1'b1 || sd_dq_out !== 16'hA5A5) begin
      n_fail++; $display("FAIL wr_write: got cmd=%b oe=%b dq=%h exp 0100/1/a5a5", cmd, sd_dq_oe, sd_dq_out); end
    n_checks++; if (sd_a !== 13'h03FF || sd_ba !== 2'd1) begin
      n_fail++; $display("FAIL wr_col: got a=%h ba=%h exp 03ff/1", sd_a, sd_ba); end
    tick();
    n_checks++; if (cmd !== NOP || sd_dq_oe !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_rec1: got cmd=%b oe=%b vld=%b exp 0111/0/0", cmd, sd_dq_oe, bus.rsp_valid); end
    tick();
    n_checks++; if (cmd !== NOP) begin n_fail++; $display("FAIL wr_rec2: got %b exp %b", cmd, NOP); end
    tick();
    n_checks++; if (cmd !== PRE || bus.rsp_valid !== 1'b1 || bus.rsp_we !== 1'b1) begin
      n_fail++; $display("FAIL wr_pre: got cmd=%b vld=%b we=%b exp 0010/1/1", cmd, bus.rsp_valid, bus.rsp_we); end
    tick(); tick(); tick();
    n_checks++; if (cmd !== DESEL || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_idle: got cmd=%b ready=%b exp 1111/1", cmd, bus.req_ready); end
  endtask

  task automatic test_timeout();
    bus.req_we = 1'b0;
    bus.req_addr = {2'd0, 13'h0001, 10'h002};
    bus.req_valid = 1'b1;
    tick(); // ACTIVATE
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_checks++; if (cmd !== NOP || rcd_start !== 1'b1 || bus.rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL to_wait%0d: got cmd=%b start=%b err=%b exp 0111/1/0", i, cmd, rcd_start, bus.rsp_err); end
    end
    tick(); // PRECHARGE
    n_checks++; if (cmd !== PRE || bus.rsp_err !== 1'b1 || bus.rsp_valid !== 1'b0 || rcd_start !== 1'b0) begin
      n_fail++; $display("FAIL to_pre: got cmd=%b err=%b vld=%b start=%b exp 0010/1/0/0", cmd, bus.rsp_err, bus.rsp_valid, rcd_start); end
    tick();
    n_checks++; if (cmd !== NOP || bus.rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL to_rp1: got cmd=%b err=%b exp 0111/0", cmd, bus.rsp_err); end
    tick(); tick();
    n_checks++; if (cmd !== DESEL || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL to_idle: got cmd=%b ready=%b d=%h exp 1111/1/beef", cmd, bus.req_ready, bus.rsp_rdata); end
  endtask

  task automatic test_spurious_done();
    rcd_done = 1'b1; // in IDLE, no request
    tick();
    rcd_done = 1'b0;
    n_checks++; if (cmd !== DESEL || rcd_start !== 1'b0) begin
      n_fail++; $display("FAIL sp_idle: got cmd=%b start=%b exp 1111/0", cmd, rcd_start); end
    bus.req_we = 1'b0;
    bus.req_addr = {2'd3, 13'h0100, 10'h010};
    bus.req_valid = 1'b1;
    tick(); // ACTIVATE
    bus.req_valid = 1'b0;
    rcd_done = 1'b1; // sampled at the edge ending ACTIVATE
    tick(); // WAIT_RCD 1
    rcd_done = 1'b0;
    n_checks++; if (cmd !== NOP) begin n_fail++; $display("FAIL sp_wait1: got %b exp %b", cmd, NOP); end
    tick(); // WAIT_RCD 2
    n_checks++; if (cmd !== NOP || rcd_start !== 1'b1) begin
      n_fail++; $display("FAIL sp_wait2: got cmd=%b start=%b exp 0111/1", cmd, rcd_start); end
    rcd_done = 1'b1;
    tick(); // READ
    rcd_done = 1'b0;
    n_checks++; if (cmd !== RD || sd_a !== 13'h0010) begin
      n_fail++; $display("FAIL sp_read: got cmd=%b a=%h exp 0101/0010", cmd, sd_a); end
    tick(); tick(); // CAS 2
    sd_dq_in = 16'h1234;
    tick(); // PRECHARGE
    sd_dq_in = 16'h0000;
    n_checks++; if (cmd !== PRE || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL sp_rsp: got cmd=%b vld=%b d=%h exp 0010/1/1234", cmd, bus.rsp_valid, bus.rsp_rdata); end
    tick(); tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [8];
    exp_seq = '{ACT, NOP, WR, NOP, NOP, PRE, NOP, NOP};
    rcd_done = 1'b1; // held: honoured on the first WAIT_RCD cycle of each access
    sd_dq_in = 16'h5A5A;
    bus.req_we = 1'b1;
    bus.req_addr = {2'd3, 13'h0055, 10'h001};
    bus.req_wdata = 16'h1111;
    bus.req_valid = 1'b1;
    tick(); // ACTIVATE (first)
    bus.req_we = 1'b0;
    bus.req_addr = {2'd0, 13'h1FFF, 10'h200};
    bus.req_wdata = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      n_checks++; if (cmd !== exp_seq[i] || bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_seq%0d: got cmd=%b ready=%b exp %b/0", i, cmd, bus.req_ready, exp_seq[i]); end
    end
    tick(); // first IDLE cycle, second request accepted here
    n_checks++; if (cmd !== DESEL || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_idle: got cmd=%b ready=%b exp 1111/1", cmd, bus.req_ready); end
    tick(); // ACTIVATE (second)
    bus.req_valid = 1'b0;
    n_checks++; if (cmd !== ACT || sd_ba !== 2'd0 || sd_a !== 13'h1FFF) begin
      n_fail++; $display("FAIL b2b_act2: got cmd=%b ba=%h a=%h exp 0011/0/1fff", cmd, sd_ba, sd_a); end
    tick(); tick(); // READ
    rcd_done = 1'b0;
    n_checks++; if (cmd !== RD || sd_a !== 13'h0200) begin
      n_fail++; $display("FAIL b2b_read: got cmd=%b a=%h exp 0101/0200", cmd, sd_a); end
    tick(); tick(); tick(); // PRECHARGE
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_we !== 1'b0 || bus.rsp_rdata !== 16'h5A5A) begin
      n_fail++; $display("FAIL b2b_rsp: got v=%b we=%b d=%h exp 1/0/5a5a", bus.rsp_valid, bus.rsp_we, bus.rsp_rdata); end
    sd_dq_in = 16'h0000;
    tick(); tick(); tick();
    n_checks++; if (cmd !== DESEL || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_end: got cmd=%b ready=%b exp 1111/1", cmd, bus.req_ready); end
  endtask

  task automatic test_reset_mid_op();
    bus.req_we = 1'b0;
    bus.req_addr = {2'd1, 13'h0042, 10'h003};
    bus.req_valid = 1'b1;
    tick(); // ACTIVATE
    bus.req_valid = 1'b0;
    tick(); // WAIT_RCD 1
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (cmd !== DESEL || rcd_start !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst: got cmd=%b start=%b ready=%b exp 1111/0/1", cmd, rcd_start, bus.req_ready); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || cmd !== DESEL) begin
        n_fail++; $display("FAIL post_rst%0d: got vld=%b err=%b cmd=%b exp 0/0/1111", i, bus.rsp_valid, bus.rsp_err, cmd); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_spurious_done();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
